mem_stage: RTL
==============

// Module: mem_stage
// PURPOSE
// Pipeline MEM stage: consumes the EXE-stage register outputs (ALU result, store data, instruction) and performs
// lw/sw against an internal word-addressed data RAM with configurable access latency. Registers the write-back
// data, destination register and write enable into the MEM/WB boundary, and stalls upstream while an access is in flight.
// PARAMETERS
// ADDR_W       8   word-address width; RAM depth = 2**ADDR_W words of 32 bits
// MEM_LATENCY  1   cycles a lw/sw occupies the stage (>=1); 1 = no stall
// PORTS
// clk              in   1   rising-edge clock
// reset            in   1   synchronous, active-low reset
// Instruction_MEM  in   32  instruction in MEM; 32'd0 = bubble
// Alu_result       in   32  byte address for lw/sw; result for R-type/addi
// Write_data_mem   in   32  store data for sw
// stall            out  1   combinational; upstream holds all inputs while 1
// Instruction_WB   out  32  registered instruction to WB
// Write_back_data  out  32  registered: load data for lw, else Alu_result
// Write_reg        out  5   registered destination: [15:11] R-type, [20:16] lw/addi, else 0
// Reg_write        out  1   registered: 1 for R-type add/sub/and/or/slt, lw, addi (non-bubble)
// misaligned       out  1   registered: 1 when completed lw/sw had Alu_result[1:0]!=0
// BEHAVIOUR
// - Decode: opcode [31:26]; lw=35, sw=43, addi=8, R-type=0 (funct 32/34/36/37/42); mem op = lw|sw; other = no write.
// - Reset (reset==0 at posedge): state<=IDLE, cnt<=0, all registered outputs 0; RAM contents untouched.
//   Reset overrides any in-flight access; an interrupted sw does not write RAM.
// - Address: word index = Alu_result[ADDR_W+1:2]; higher bits ignored (address wraps modulo depth).
// - Misaligned (Alu_result[1:0]!=0): sw writes nothing, lw returns 32'd0; misaligned=1 with that op's WB outputs.
// - FSM states IDLE, WAIT; cnt is ceil(log2(MEM_LATENCY)) bits (min 1).
//   IDLE, non-mem or bubble: stall=0; complete this cycle.
//   IDLE, mem op, MEM_LATENCY==1: stall=0; complete this cycle.
//   IDLE, mem op, MEM_LATENCY>1: stall=1; -> WAIT, cnt<=MEM_LATENCY-2.
//   WAIT, cnt!=0: stall=1; cnt<=cnt-1.   WAIT, cnt==0: stall=0; complete; -> IDLE.
// - Complete (at that posedge): sw writes Write_data_mem to RAM[word]; WB regs load Instruction_MEM,
//   Write_back_data (lw: RAM[word] as read before this edge, else Alu_result), Write_reg, Reg_write, misaligned.
// - Any cycle with stall=1: WB regs load bubble (Instruction_WB=0, Reg_write=0, Write_reg=0, data 0, misaligned 0).
// - Bubble in IDLE: WB regs load bubble; RAM untouched.
// - Latency: non-mem = 1 cycle; mem op = MEM_LATENCY cycles; one op in flight max, no back-to-back overlap.
// - Inputs are sampled only in the completing cycle; changes while stall=1 are a protocol violation (undefined).
// - lw after sw to same address in consecutive completions returns the stored value (write at edge, read next op).
// - Write_reg for a destination of $0 is passed through unchanged; WB is responsible for ignoring $0.
// TESTING
// 1 Reset: hold reset=0 2 cycles with Instruction_MEM=sw -> all outputs 0, stall=0, subsequent lw of that addr != data.
// 2 LAT=1: sw Alu_result=0x10 data 0xDEADBEEF, then lw rt=5 addr 0x10 -> Write_back_data=0xDEADBEEF,
//   Write_reg=5, Reg_write=1 one cycle after lw presented; stall never 1.
// 3 LAT=3: lw presented -> stall=1,1,0 over 3 cycles; Instruction_WB=0 for 2 edges, lw appears on 3rd edge.
// 4 R-type add rd=9, Alu_result=0x1234 -> next cycle Write_back_data=0x1234, Write_reg=9, Reg_write=1; beq -> Reg_write=0.
// 5 Wrap/misalign (ADDR_W=8): sw addr 0x400 data 7, lw addr 0x000 -> 7; sw addr 0x13 -> misaligned=1, RAM unchanged.
// 6 LAT=4: sw issued, reset=0 on 2nd stall cycle -> FSM IDLE, stall=0 next cycle, lw of that addr returns prior value.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: pipeline MEM stage with an internal word-addressed data RAM.
// Executes lw/sw with a configurable access latency and stalls upstream while an access is in flight.
// Registers the write-back data, destination register and write enable into the MEM/WB boundary.
module mem_stage #(
    parameter int ADDR_W      = 8,
    parameter int MEM_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instruction_MEM,
    input  logic [31:0] Alu_result,
    input  logic [31:0] Write_data_mem,
    output logic        stall,
    output logic [31:0] Instruction_WB,
    output logic [31:0] Write_back_data,
    output logic [4:0]  Write_reg,
    output logic        Reg_write,
    output logic        misaligned
);

    localparam int CNT_W = (MEM_LATENCY > 2) ? $clog2(MEM_LATENCY) : 1;
    localparam int DEPTH = 2 ** ADDR_W;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;
    localparam logic [5:0] OP_ADDI  = 6'd8;

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [31:0]        ram [0:DEPTH-1];

    logic [5:0]         opcode;
    logic [5:0]         funct;
    logic               is_bubble;
    logic               is_lw;
    logic               is_sw;
    logic               is_addi;
    logic               is_rtype;
    logic               mem_op;
    logic               unaligned;
    logic [ADDR_W-1:0]  word;

    logic [31:0]        nxt_instr;
    logic [31:0]        nxt_data;
    logic [4:0]         nxt_reg;
    logic               nxt_we;
    logic               nxt_mis;

    // Instruction decode and address split; high address bits fall off so accesses wrap modulo depth.
    always_comb begin
        opcode    = Instruction_MEM[31:26];
        funct     = Instruction_MEM[5:0];
        is_bubble = (Instruction_MEM == 32'd0);
        is_lw     = (opcode == OP_LW);
        is_sw     = (opcode == OP_SW);
        is_addi   = (opcode == OP_ADDI);
        is_rtype  = (opcode == OP_RTYPE) &&
                    ((funct == 6'd32) || (funct == 6'd34) || (funct == 6'd36) ||
                     (funct == 6'd37) || (funct == 6'd42));
        mem_op    = is_lw || is_sw;
        unaligned = (Alu_result[1:0] != 2'b00);
        word      = Alu_result[ADDR_W+1:2];
    end

    // Upstream must hold while an access has cycles left; the completing cycle never stalls.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        stall = 1'b0;
        if (state == IDLE) begin
            stall = mem_op && (MEM_LATENCY > 1);
        end else begin
            stall = (cnt != '0);
        end
    end

    // Next MEM/WB contents: bubble while stalling or for a bubble input, else the completed op.
    always_comb begin
        nxt_instr = 32'd0;
        nxt_data  = 32'd0;
        nxt_reg   = 5'd0;
        nxt_we    = 1'b0;
        nxt_mis   = 1'b0;
        if (!stall && !is_bubble) begin
            nxt_instr = Instruction_MEM;
            if (is_lw) begin
                nxt_data = unaligned ? 32'd0 : ram[word];
            end else begin
                nxt_data = Alu_result;
            end
            if (is_rtype) begin
                nxt_reg = Instruction_MEM[15:11];
            end else if (is_lw || is_addi) begin
                nxt_reg = Instruction_MEM[20:16];
            end
            nxt_we  = is_rtype || is_lw || is_addi;
            nxt_mis = mem_op && unaligned;
        end
    end

    // Access-latency FSM plus the registered MEM/WB boundary.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!reset) begin
            state           <= IDLE;
            cnt             <= '0;
            Instruction_WB  <= 32'd0;
            Write_back_data <= 32'd0;
            Write_reg       <= 5'd0;
            Reg_write       <= 1'b0;
            misaligned      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_op && (MEM_LATENCY > 1)) begin
                        state <= WAIT;
                        cnt   <= CNT_W'(MEM_LATENCY - 2);
                    end
                end
                WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            Instruction_WB  <= nxt_instr;
            Write_back_data <= nxt_data;
            Write_reg       <= nxt_reg;
            Reg_write       <= nxt_we;
            misaligned      <= nxt_mis;
        end
    end

    // Store port: aligned sw writes only on its completing edge, and never while reset is asserted.
    always_ff @(posedge clk) begin
        // NOTE: RAM contents are deliberately not reset; reset only blocks an in-flight store.
        if (reset && is_sw && !unaligned && !stall) begin
            ram[word] <= Write_data_mem;
        end
    end

endmodule
